// File: rtl/gray_pkg.sv
// gray_pkg: shared constants and pure conversion functions for the Gray/binary
// converter. The functions work on a 32-bit container and take the active
// code width as an argument, so RTL and reference models share one definition.
package gray_pkg;

   localparam logic MODE_G2B = 1'b0;   // Gray-to-binary
   localparam logic MODE_B2G = 1'b1;   // binary-to-Gray

   // Mask with the low w bits set (w in 1..32).
   function automatic logic [31:0] width_mask(input int w);
      if (w >= 32) begin
         return 32'hFFFF_FFFF;
      end else begin
         return (32'd1 << w) - 32'd1;
      end
   endfunction

   // Gray-to-binary: prefix XOR from the MSB down. Bits above w are cleared
   // first, so the chain starts at zero and b[w-1] = g[w-1].
   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
      logic [31:0] gm;
      logic [31:0] b;
      gm = g & width_mask(w);
      b  = gm;
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ gm[i];
      end
      return b;
   endfunction

   // Binary-to-Gray: b ^ (b >> 1), zero-filled at the MSB of the w-bit word.
   function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
      logic [31:0] bm;
      bm = b & width_mask(w);
      return bm ^ (bm >> 1);
   endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// gray_pipe_stage: one valid/mode/data register slice with load enable.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en_i                load enable (stage holds when low)
//   valid_i/mode_i/data_i   incoming word
//   valid_o/mode_o/data_o   registered word
// Mode and data only load with a valid word, so a drained stage keeps the
// last word on its outputs.
module gray_pipe_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             valid_i,
   input  logic             mode_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic             mode_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q;
   logic             mode_q;
   logic [WIDTH-1:0] data_q;

   // Stage register: load on enable, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         mode_q  <= 1'b0;
         data_q  <= '0;
      end else if (en_i) begin
         valid_q <= valid_i;
         if (valid_i) begin
            mode_q <= mode_i;
            data_q <= data_i;
         end else begin
            mode_q <= mode_q;
            data_q <= data_q;
         end
      end else begin
         valid_q <= valid_q;
         mode_q  <= mode_q;
         data_q  <= data_q;
      end
   end

   assign valid_o = valid_q;
   assign mode_o  = mode_q;
   assign data_o  = data_q;

endmodule

// File: rtl/gray_bin_conv_pipe.sv
// gray_bin_conv_pipe: two-stage pipelined bidirectional Gray/binary converter
// with valid/ready handshakes and a wrapping output-handshake counter.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid_i/in_ready_o              input handshake
//   in_mode_i (0 = G2B, 1 = B2G), in_data_i   input word
//   out_valid_o/out_ready_i            output handshake
//   out_mode_o, out_data_o             result and the mode it used
//   out_count_o                        completed output handshakes mod 2^CNT_W
// Gray-to-binary is split across the stages: S1 resolves the upper half,
// S2 finishes the lower half seeded by S1's bit H. Binary-to-Gray finishes
// in S1 and S2 just carries it.
module gray_bin_conv_pipe
   import gray_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             in_mode_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             out_mode_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic [CNT_W-1:0] out_count_o
);

   localparam int H = WIDTH / 2;

   logic             s1_en_s;
   logic             s2_en_s;
   logic             s1_valid_s;
   logic             s1_mode_s;
   logic [WIDTH-1:0] s1_data_s;
   logic [WIDTH-1:0] s1_data_d;
   logic [WIDTH-1:0] g2b_full_s;
   logic [WIDTH-1:0] b2g_full_s;
   logic [WIDTH-1:0] s2_data_d;
   logic             s2_valid_s;
   logic [CNT_W-1:0] out_count_q;

   // Stall chain: a stage may load when it is empty or the one after it moves.
   assign s2_en_s    = !s2_valid_s || out_ready_i;
   assign s1_en_s    = !s1_valid_s || s2_en_s;
   assign in_ready_o = s1_en_s;

   assign g2b_full_s = WIDTH'(gray2bin(32'(in_data_i), WIDTH));
   assign b2g_full_s = WIDTH'(bin2gray(32'(in_data_i), WIDTH));

   // S1 input: G2B keeps the lower Gray half raw for S2 to finish.
   always_comb begin
      if (in_mode_i == MODE_G2B) begin
         s1_data_d = {g2b_full_s[WIDTH-1:H], in_data_i[H-1:0]};
      end else begin
         s1_data_d = b2g_full_s;
      end
   end

   gray_pipe_stage #(.WIDTH(WIDTH)) u_s1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (s1_en_s),
      .valid_i (in_valid_i),
      .mode_i  (in_mode_i),
      .data_i  (s1_data_d),
      .valid_o (s1_valid_s),
      .mode_o  (s1_mode_s),
      .data_o  (s1_data_s)
   );

   // S2 input: finish the lower half by prefix XOR, seeded with binary bit H.
   always_comb begin
      s2_data_d = s1_data_s;
      if (s1_mode_s == MODE_G2B) begin
         for (int i = H - 1; i >= 0; i--) begin
            s2_data_d[i] = s2_data_d[i+1] ^ s1_data_s[i];
         end
      end else begin
         s2_data_d = s1_data_s;
      end
   end

   gray_pipe_stage #(.WIDTH(WIDTH)) u_s2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (s2_en_s),
      .valid_i (s1_valid_s),
      .mode_i  (s1_mode_s),
      .data_i  (s2_data_d),
      .valid_o (s2_valid_s),
      .mode_o  (out_mode_o),
      .data_o  (out_data_o)
   );

   assign out_valid_o = s2_valid_s;

   // Output-handshake counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_count_q <= '0;
      end else if (s2_valid_s && out_ready_i) begin
         out_count_q <= out_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         out_count_q <= out_count_q;
      end
   end

   assign out_count_o = out_count_q;

endmodule
